apb_cmd_master: RTL and testbench

Single-channel APB master that turns a simple valid/ready command stream into APB transfers and returns one response per command. Sits directly upstream of the APB timer slave: it drives `psel`/`penable`/`pwrite`/`paddr`/`pwdata` and consumes `prdata`/`pready`/`pslverr`. A firmware or test sequencer on the command side programs the timer without knowing APB phase rules. A bounded wait-state timeout prevents a stuck slave from hanging the command stream.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_cmd_master_if.sv | 34 +++
 rtl/apb_cmd_master.sv | 69 ++++++
 tb/tb_apb_cmd_master.sv | 134 +++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master state, command/response types and default widths
package apb_pkg;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  typedef enum logic [2:0] {RST_MARK, IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command stream, response stream and APB bus bundle
interface apb_cmd_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into APB transfers with a wait-state timeout
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input logic              pclk,
  input logic              preset_n,
  apb_cmd_master_if.master bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  apb_mst_state_e state;
  logic [CW-1:0]  cnt;
  logic           timed_out;
  assign bus.cmd_ready = state == IDLE;
  assign timed_out = TIMEOUT != 0 && cnt == LIM;
  // transfer sequencer; every bus and response output is a register written here
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state           <= RST_MARK;
      cnt             <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        RST_MARK: state <= IDLE;
        IDLE: if (bus.cmd_valid) begin
          state      <= SETUP;
          cnt        <= '0;
          bus.psel   <= 1'b1;
          bus.pwrite <= bus.cmd_write;
          bus.paddr  <= bus.cmd_addr;
          bus.pwdata <= bus.cmd_wdata;
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end
        ACCESS: if (bus.pready || timed_out) begin
          state           <= RESP;
          bus.psel        <= 1'b0;
          bus.penable     <= 1'b0;
          bus.pwrite      <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= bus.pready && !bus.pwrite ? bus.prdata : '0;
          bus.rsp_err     <= bus.pready ? bus.pslverr : 1'b1;
          bus.rsp_timeout <= !bus.pready;
        end else begin
          cnt <= cnt == '1 ? cnt : cnt + 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed checks of apb_cmd_master against hand-computed expectations
module tb_apb_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int n;
  apb_cmd_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  apb_cmd_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (.pclk(clk), .preset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.rsp_ready = 1; bus.prdata = 0; bus.pready = 1; bus.pslverr = 0;
    #23;
    chk("rst_outs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.pwrite}, 0);
    chk("rst_bus", {bus.paddr, bus.pwdata, bus.rsp_rdata}, 0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", bus.cmd_ready, 1);
    send(1, 8'h02, 8'h64);
    chk("wr_setup", {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready, bus.paddr, bus.pwdata}, {4'b1010, 8'h02, 8'h64});
    tick();
    chk("wr_access", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, {3'b111, 8'h02, 8'h64});
    tick();
    chk("wr_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.penable, bus.pwrite, bus.rsp_rdata}, {6'b100000, 8'h00});
    tick();
    chk("wr_idle", {bus.cmd_ready, bus.rsp_valid, bus.paddr, bus.pwdata}, {2'b10, 8'h02, 8'h64});
    bus.pready = 0; bus.prdata = 8'h5A;
    send(0, 8'h01, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("rd_wait4", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.paddr}, {4'b1100, 8'h01});
    bus.pready = 1;
    tick();
    chk("rd_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {3'b100, 8'h5A});
    bus.prdata = 8'hAA;
    tick();
    bus.pslverr = 1;
    send(1, 8'h07, 8'h11);
    tick();
    tick();
    chk("err_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {3'b110, 8'h00});
    bus.pslverr = 0;
    tick();
    bus.pready = 0; bus.prdata = 8'hFF;
    send(0, 8'h03, 8'h00);
    tick();
    n = 0;
    while (bus.penable && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 16);
    chk("to_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.psel, bus.rsp_rdata}, {4'b1110, 8'h00});
    tick();
    bus.pready = 1; bus.prdata = 8'h33;
    chk("to_next_rdy", bus.cmd_ready, 1);
    send(0, 8'h04, 8'h00);
    tick();
    tick();
    chk("to_next_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {3'b100, 8'h33});
    tick();
    send(1, 8'h00, 8'h80);
    chk("s1_setup", {bus.paddr, bus.pwdata}, {8'h00, 8'h80});
    tick();
    tick();
    chk("s1_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 8'h00});
    tick();
    send(1, 8'h00, 8'h3B);
    chk("s2_setup", {bus.psel, bus.pwrite, bus.pwdata}, {2'b11, 8'h3B});
    tick();
    tick();
    bus.rsp_ready = 0;
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 8'h01; bus.prdata = 8'h7C;
    for (int i = 0; i < 5; i++) begin
      chk("s2_stall", {bus.rsp_valid, bus.cmd_ready, bus.psel, bus.penable, bus.rsp_err}, 5'b10000);
      tick();
    end
    bus.rsp_ready = 1;
    tick();
    chk("s2_released", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    tick();
    bus.cmd_valid = 0;
    chk("s3_setup", {bus.psel, bus.penable, bus.pwrite, bus.paddr}, {3'b100, 8'h01});
    tick();
    tick();
    chk("s3_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b10, 8'h7C});
    tick();
    bus.pready = 0;
    send(1, 8'h05, 8'h99);
    tick();
    chk("mid_access", {bus.psel, bus.penable}, 2'b11);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 4'b0000);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst", {bus.cmd_ready, bus.rsp_valid, bus.psel}, 3'b100);
    bus.pready = 1; bus.prdata = 8'h42;
    send(0, 8'h06, 8'h00);
    tick();
    tick();
    chk("post_rst_resp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {3'b100, 8'h42});
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
